// File: rtl/sequenciador_pkg.sv
// sequenciador_pkg: state encodings and timing defaults shared by the memory game controller
package sequenciador_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    LE_RAM         = 4'h2,
    MOSTRA         = 4'h3,
    APAGA          = 4'h4,
    ESPERA_JOGADA  = 4'h5,
    COMPARA        = 4'h6,
    ESPERA_ESCRITA = 4'h7,
    ESCREVE        = 4'h8,
    FIM_ACERTO     = 4'h9,
    FIM_ERRO       = 4'hA,
    FIM_TIMEOUT    = 4'hB
  } estado_t;
  localparam int SHOW_DEFAULT = 1000;
  localparam int GAP_DEFAULT = 250;
  localparam int TIMEOUT_DEFAULT = 5000;
  localparam logic [3:0] LAST_ROUND = 4'd15;
endpackage

// File: rtl/contador_m.sv
// contador_m: mod-M counter with synchronous clear and enable, fim flags the terminal count
module contador_m #(
  parameter int M = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fim
);
  localparam int W = M > 1 ? $clog2(M) : 1;
  logic [W-1:0] q;
  // count 0..M-1 while enabled, wrapping after the terminal count
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en) q <= fim ? '0 : q + W'(1);
  assign fim = q == W'(M - 1);
endmodule

// File: rtl/sequenciador_memoria.sv
// sequenciador_memoria: memory game controller driving playback, press checking and RAM writes
module sequenciador_memoria
  import sequenciador_pkg::*;
#(
  parameter int SHOW_CYCLES = SHOW_DEFAULT,
  parameter int GAP_CYCLES = GAP_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  input  logic [3:0] ram_q,
  output logic [3:0] ram_addr,
  output logic       ram_we,
  output logic [3:0] ram_data,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] rodada,
  output logic [3:0] estado_db
);
  estado_t estado, prox;
  logic [3:0] botoes_q, jogada;
  logic press, esperando, acerto, fim_show, fim_gap, fim_to;
  assign press = (|botoes) && !(|botoes_q);
  assign esperando = estado == ESPERA_JOGADA || estado == ESPERA_ESCRITA;
  assign acerto = jogada == ram_q;
  contador_m #(.M(SHOW_CYCLES)) u_show (.clk(clk), .rst(reset), .clr(estado != MOSTRA), .en(estado == MOSTRA), .fim(fim_show));
  contador_m #(.M(GAP_CYCLES)) u_gap (.clk(clk), .rst(reset), .clr(estado != APAGA), .en(estado == APAGA), .fim(fim_gap));
  contador_m #(.M(TIMEOUT_CYCLES)) u_to (.clk(clk), .rst(reset), .clr(!esperando), .en(esperando), .fim(fim_to));
  // state register
  always_ff @(posedge clk)
    if (reset) estado <= INICIAL;
    else estado <= prox;
  // next state; a press beats a simultaneous timeout
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:        prox = iniciar ? PREPARA : INICIAL;
      PREPARA:        prox = LE_RAM;
      LE_RAM:         prox = MOSTRA;
      MOSTRA:         prox = fim_show ? APAGA : MOSTRA;
      APAGA:          prox = !fim_gap ? APAGA : ram_addr == rodada ? ESPERA_JOGADA : LE_RAM;
      ESPERA_JOGADA:  prox = press ? COMPARA : fim_to ? FIM_TIMEOUT : ESPERA_JOGADA;
      COMPARA:        prox = !acerto ? FIM_ERRO : ram_addr < rodada ? ESPERA_JOGADA :
                             rodada == LAST_ROUND ? FIM_ACERTO : ESPERA_ESCRITA;
      ESPERA_ESCRITA: prox = press ? ESCREVE : fim_to ? FIM_TIMEOUT : ESPERA_ESCRITA;
      ESCREVE:        prox = LE_RAM;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: prox = iniciar ? PREPARA : estado;
      default:        prox = INICIAL;
    endcase
  end
  // address, round, press latches and the button edge register
  always_ff @(posedge clk)
    if (reset) begin
      ram_addr <= '0;
      rodada <= '0;
      ram_data <= '0;
      jogada <= '0;
      botoes_q <= '0;
    end else begin
      botoes_q <= botoes;
      if (estado == ESPERA_JOGADA && press) jogada <= botoes;
      if (estado == ESPERA_ESCRITA && press) ram_data <= botoes;
      case (estado)
        PREPARA: begin
          ram_addr <= '0;
          rodada <= '0;
        end
        APAGA: if (fim_gap) ram_addr <= ram_addr == rodada ? 4'd0 : ram_addr + 4'd1;
        COMPARA:
          if (acerto && ram_addr < rodada) ram_addr <= ram_addr + 4'd1;
          else if (acerto && rodada != LAST_ROUND) ram_addr <= rodada + 4'd1;
        ESCREVE: begin
          rodada <= rodada + 4'd1;
          ram_addr <= '0;
        end
        default: ;
      endcase
    end
  assign leds = estado == MOSTRA ? ram_q : 4'd0;
  assign ram_we = estado == ESCREVE;
  assign ganhou = estado == FIM_ACERTO;
  assign perdeu = estado == FIM_ERRO;
  assign timeout = estado == FIM_TIMEOUT;
  assign pronto = ganhou || perdeu || timeout;
  assign estado_db = estado;
endmodule

// File: doc/sequenciador_memoria.md
Name: sequenciador_memoria

Overview:
- Control unit for the memory-challenge game. Drives the 16x4 synchronous game RAM: plays back the stored sequence on the LEDs, checks the player's presses against the RAM, and writes each new player-chosen jogada into the RAM.
- Sits between the debounced button inputs, the LED outputs and the RAM instance. The RAM is external; this block only drives its addr/we/data and reads its q.

Parameters:
- SHOW_CYCLES, 1000, clock cycles each sequence item is lit on leds.
- GAP_CYCLES, 250, clock cycles with leds dark between items.
- TIMEOUT_CYCLES, 5000, cycles allowed per player press before a timeout loss.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start a new game, level-sampled.
- botoes  in  4  debounced, synchronous one-hot buttons.
- ram_q  in  4  RAM read data; valid 1 cycle after ram_addr changes.
- ram_addr  out  4  RAM address.
- ram_we  out  1  RAM write enable.
- ram_data  out  4  RAM write data.
- leds  out  4  LED drive.
- pronto  out  1  game finished.
- ganhou  out  1  win flag.
- perdeu  out  1  wrong-press loss flag.
- timeout  out  1  timeout loss flag.
- rodada  out  4  current round index.
- estado_db  out  4  state code, for debug.

Behaviour:
- Reset (synchronous, active-high, one clock, one cycle) applies in every state, including mid-round, mid-show and the write cycle:
  - state goes to INICIAL;
  - leds, ram_addr, ram_data, rodada, pronto, ganhou, perdeu and timeout go to 0;
  - ram_we=0 and all counters are cleared.
- RAM contents are not touched by reset. Address 0 always holds 0001 because the controller never writes address 0.
- Press detection: botoes is registered once. A press is the cycle where |botoes rises from 0 to 1. The value sampled is botoes in that cycle. Held buttons never retrigger.
- States (estado_db codes 0..B):
  - INICIAL: all flags 0. iniciar=1 → PREPARA.
  - PREPARA: rodada=0, ram_addr=0, flags cleared → LE_RAM.
  - LE_RAM: 1-cycle wait for the RAM's registered address → MOSTRA.
  - MOSTRA: leds=ram_q for SHOW_CYCLES cycles → APAGA.
  - APAGA: leds=0 for GAP_CYCLES cycles. Then:
    - if ram_addr==rodada: ram_addr=0 → ESPERA_JOGADA;
    - otherwise ram_addr+1 → LE_RAM.
  - ESPERA_JOGADA: timeout counter runs.
    - Press: latch jogada → COMPARA.
    - Counter reaches TIMEOUT_CYCLES-1 with no press → FIM_TIMEOUT.
    - If a press and the terminal count fall in the same cycle, the press wins.
  - COMPARA: ram_addr has been stable for at least 1 cycle, so ram_q is valid.
    - jogada≠ram_q → FIM_ERRO.
    - Match and ram_addr<rodada: ram_addr+1, timeout counter cleared → ESPERA_JOGADA.
    - Match, ram_addr==rodada, rodada==15 → FIM_ACERTO.
    - Match otherwise: ram_addr=rodada+1 → ESPERA_ESCRITA.
  - ESPERA_ESCRITA: timeout counter runs, same rules as ESPERA_JOGADA.
    - Press: ram_data=botoes → ESCREVE.
  - ESCREVE: ram_we=1 for exactly this cycle. rodada+1, ram_addr=0 → LE_RAM (the next round's playback).
  - FIM_ACERTO: ganhou=1, pronto=1.
  - FIM_ERRO: perdeu=1, pronto=1.
  - FIM_TIMEOUT: timeout=1, pronto=1.
  - All FIM_* states hold until iniciar=1 → PREPARA, which clears the flags.
- In any state other than ESCREVE: ram_we=0.
- In any state other than MOSTRA: leds=0.
- Arithmetic: ram_addr and rodada are 4-bit and never wrap. rodada==15 is terminal.
- iniciar is ignored outside INICIAL and the FIM_* states.
- Presses outside ESPERA_JOGADA and ESPERA_ESCRITA are discarded; the edge register still updates.

Decomposition:
- Shared package sequenciador_pkg holds:
  - state encodings (4-bit localparams, values as listed above);
  - the SHOW/GAP/TIMEOUT defaults;
  - LAST_ROUND=15.
- One natural sub-module: contador_m. It is a parameterised mod-M counter with synchronous clear and enable, output fim at M-1. It is instantiated three times: show, gap and timeout.

Test Plan:
All tests use SHOW_CYCLES=3, GAP_CYCLES=2, TIMEOUT_CYCLES=10, with a behavioural RAM model (addr0=0001).
1. reset mid-MOSTRA → next cycle estado_db=0, leds=0000, ram_we=0, all flags 0; RAM addr0 still 0001.
2. iniciar pulse → leds=0001 for exactly 3 cycles starting 2 cycles after PREPARA, then 0000 for 2 cycles. Press 0001 → ESPERA_ESCRITA with ram_addr=1. Press 0100 → one ram_we pulse at addr1, data 0100. Playback round 1 shows 0001 then 0100.
3. Round 1, player presses 0001 then 1000 (expected 0100) → perdeu=1, pronto=1, ganhou=0, timeout=0. Held until iniciar.
4. ESPERA_JOGADA with no press for 10 cycles → timeout=1, pronto=1. A press arriving on cycle 10 instead → COMPARA, no timeout.
5. Play 16 correct rounds (writing addr 1..15) → ganhou=1 after the round-15 compare. No write to addr 0 is ever observed and no ram_we pulse occurs after round 15.
6. Button held high across two compare windows → counted as one press only. Subsequent timeout occurs.
